// File: rtl/seq_det_pkg.sv
// Shared types, defaults and the masked compare helper for the
// parametrised serial pattern detector.
package seq_det_pkg;

   localparam int MAX_PAT_LEN = 16;
   localparam int DEF_PAT_LEN = 4;

   localparam logic [MAX_PAT_LEN-1:0] DEF_PAT  = 16'h0007;
   localparam logic [MAX_PAT_LEN-1:0] DEF_MASK = '1;

   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } state_t;

   // Callers zero-extend narrower operands; zero mask bits make the upper
   // positions don't-care.
   function automatic logic pat_match(input logic [MAX_PAT_LEN-1:0] hist,
                                      input logic [MAX_PAT_LEN-1:0] pat,
                                      input logic [MAX_PAT_LEN-1:0] mask);
      return ((hist ^ pat) & mask) == '0;
   endfunction

endpackage

// File: rtl/seq_shift_hist.sv
// History shift register, fill counter and the FILL/ARMED tracker.
// Exposes the registered history and a look-ahead "full after this bit" flag.
module seq_shift_hist
   import seq_det_pkg::*;
#(
   parameter int PAT_LEN = DEF_PAT_LEN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_accept,
   input  logic               i_bit,
   input  logic               i_clear,
   output logic [PAT_LEN-1:0] o_hist,
   output logic               o_full_next,
   output logic               o_armed
);

   localparam int FILL_W = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_LEN);
   localparam logic [FILL_W-1:0] FULL_M1 = FILL_W'(PAT_LEN - 1);

   logic [PAT_LEN-1:0] r_hist;
   logic [FILL_W-1:0]  r_fill;
   state_t             r_state;
   state_t             w_state_next;
   logic               w_full_next;

   assign w_full_next = i_accept && ((r_fill == FULL) || (r_fill == FULL_M1));
   assign o_full_next = w_full_next;
   assign o_hist      = r_hist;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (i_accept) begin
         r_hist <= {r_hist[PAT_LEN-2:0], i_bit};
         if (r_fill != FULL) begin
            r_fill <= r_fill + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         FILL:    if (!i_clear && w_full_next) w_state_next = ARMED;
         ARMED:   if (i_clear)                 w_state_next = FILL;
         default: w_state_next = FILL;
      endcase
   end

   always_comb begin
      o_armed = (r_state == ARMED);
   end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: runtime-loadable pattern and mask,
// overlap/non-overlap mode, registered match pulse and saturating counter.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                 PAT_LEN      = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] DEFAULT_PAT  = DEF_PAT[PAT_LEN-1:0],
   parameter logic [PAT_LEN-1:0] DEFAULT_MASK = '1,
   parameter bit                 OVERLAP      = 1'b1,
   parameter int                 CNT_W        = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in,
   input  logic               pat_load,
   input  logic [PAT_LEN-1:0] pat_in,
   input  logic [PAT_LEN-1:0] mask_in,
   input  logic               cnt_clr,
   output logic               out,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               armed
);

   logic               w_accept;
   logic               w_clear;
   logic               w_full_next;
   logic               w_match;
   logic               w_armed;
   logic [PAT_LEN-1:0] w_hist;
   logic [PAT_LEN-1:0] w_hist_next;

   logic [PAT_LEN-1:0] r_pat;
   logic [PAT_LEN-1:0] r_mask;
   logic               r_out;
   logic [CNT_W-1:0]   r_cnt;

   // A load cycle swallows the data bit, so it can never complete a match.
   assign w_accept    = in_valid && !pat_load;
   assign w_hist_next = {w_hist[PAT_LEN-2:0], in};
   assign w_match     = w_accept && w_full_next &&
                        pat_match(MAX_PAT_LEN'(w_hist_next),
                                  MAX_PAT_LEN'(r_pat),
                                  MAX_PAT_LEN'(r_mask));
   assign w_clear     = pat_load || (w_match && !OVERLAP);

   seq_shift_hist #(
      .PAT_LEN (PAT_LEN)
   ) u_hist (
      .clk         (clk),
      .rst         (rst),
      .i_accept    (w_accept),
      .i_bit       (in),
      .i_clear     (w_clear),
      .o_hist      (w_hist),
      .o_full_next (w_full_next),
      .o_armed     (w_armed)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pat  <= DEFAULT_PAT;
         r_mask <= DEFAULT_MASK;
         r_out  <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_out <= w_match;
         if (pat_load) begin
            r_pat  <= pat_in;
            r_mask <= mask_in;
         end
         // Clear beats a coincident match; the pulse itself is unaffected.
         if (cnt_clr) begin
            r_cnt <= '0;
         end else if (w_match && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign out       = r_out;
   assign match_cnt = r_cnt;
   assign armed     = w_armed;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: two detectors (overlapping/8-bit count, non-overlapping/
// 2-bit count) share one stimulus stream and are compared to a bit-list model.
module tb_seq_detector_param;

   localparam int         PAT_LEN = 4;
   localparam logic [3:0] DEF_P   = 4'b0111;

   typedef struct {
      bit out;
      int cnt;
      bit armed;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_bit;
   logic       pat_load;
   logic [3:0] pat_in;
   logic [3:0] mask_in;
   logic       cnt_clr;

   logic       out0, out1;
   logic       armed0, armed1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;

   exp_t       q0[$];
   exp_t       q1[$];
   bit         mh0[$];
   bit         mh1[$];
   logic [3:0] mpat[2];
   logic [3:0] mmask[2];
   int         mcnt[2];

   int n_checks = 0;
   int n_pass   = 0;

   seq_detector_param #(
      .PAT_LEN (PAT_LEN),
      .OVERLAP (1'b1),
      .CNT_W   (8)
   ) dut_ov (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in        (in_bit),
      .pat_load  (pat_load),
      .pat_in    (pat_in),
      .mask_in   (mask_in),
      .cnt_clr   (cnt_clr),
      .out       (out0),
      .match_cnt (cnt0),
      .armed     (armed0)
   );

   seq_detector_param #(
      .PAT_LEN (PAT_LEN),
      .OVERLAP (1'b0),
      .CNT_W   (2)
   ) dut_nov (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in        (in_bit),
      .pat_load  (pat_load),
      .pat_in    (pat_in),
      .mask_in   (mask_in),
      .cnt_clr   (cnt_clr),
      .out       (out1),
      .match_cnt (cnt1),
      .armed     (armed1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: keep the list of bits accepted since the last clear and test
   // the newest PAT_LEN of them, first-arriving bit against pattern MSB.
   task automatic model(input int m, input bit overlap, input int cnt_max,
                        inout bit h[$], output exp_t e);
      bit match;
      match = 1'b0;
      if (rst) begin
         h.delete();
         mpat[m]  = DEF_P;
         mmask[m] = 4'hF;
         mcnt[m]  = 0;
      end else begin
         if (pat_load) begin
            mpat[m]  = pat_in;
            mmask[m] = mask_in;
            h.delete();
         end else if (in_valid) begin
            h.push_back(in_bit);
            if (h.size() > PAT_LEN) void'(h.pop_front());
            if (h.size() == PAT_LEN) begin
               match = 1'b1;
               for (int i = 0; i < PAT_LEN; i++)
                  if (mmask[m][PAT_LEN-1-i] && (h[i] != mpat[m][PAT_LEN-1-i]))
                     match = 1'b0;
               if (match && !overlap) h.delete();
            end
         end
         if (cnt_clr) mcnt[m] = 0;
         else if (match && mcnt[m] < cnt_max) mcnt[m]++;
      end
      e.out   = match;
      e.cnt   = mcnt[m];
      e.armed = (h.size() == PAT_LEN);
   endtask

   task automatic step(input bit r, input bit v, input bit b, input bit ld,
                       input logic [3:0] p, input logic [3:0] mk, input bit clr);
      exp_t e;
      rst = r; in_valid = v; in_bit = b; pat_load = ld;
      pat_in = p; mask_in = mk; cnt_clr = clr;
      model(0, 1'b1, 255, mh0, e);
      q0.push_back(e);
      model(1, 1'b0, 3, mh1, e);
      q1.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
   endtask

   task automatic send_bit(input bit b);
      step(1'b0, 1'b1, b, 1'b0, 4'h0, 4'h0, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
   endtask

   task automatic load(input logic [3:0] p, input logic [3:0] mk);
      step(1'b0, 1'b1, 1'b1, 1'b1, p, mk, 1'b0);
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) send_bit(bits[n-1-i]);
   endtask

   // Monitor: one expected response per clock edge, compared mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         check("out_ov", int'(out0), int'(e.out));
         check("cnt_ov", int'(cnt0), e.cnt);
         check("armed_ov", int'(armed0), int'(e.armed));
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check("out_nov", int'(out1), int'(e.out));
         check("cnt_nov", int'(cnt1), e.cnt);
         check("armed_nov", int'(armed1), int'(e.armed));
      end
   end

   initial begin
      // Defaults 0111: pulse after 4th bit only.
      do_reset();
      do_reset();
      check("reset_out", int'(out0), 0);
      check("reset_armed", int'(armed0), 0);
      send_bits(16'b011, 3);
      send_bit(1'b1);
      check("dflt_pulse", int'(out0), 1);
      send_bit(1'b1);
      check("dflt_no_5th", int'(out0), 0);
      check("dflt_cnt", int'(cnt0), 1);

      // Overlap vs non-overlap on 0101.
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
      load(4'b0101, 4'hF);
      send_bits(16'b010101, 6);
      check("ovl_cnt", int'(cnt0), 2);
      check("novl_cnt", int'(cnt1), 1);

      // Mask 1011 on 0111: bit 2 is don't care.
      load(4'b0111, 4'b1011);
      send_bits(16'b0011, 4);
      load(4'b0111, 4'b1011);
      send_bits(16'b1011, 4);

      // Gaps in in_valid.
      load(DEF_P, 4'hF);
      send_bits(16'b01, 2);
      repeat (3) idle();
      send_bits(16'b11, 2);
      check("gap_pulse", int'(out0), 1);

      // Reset mid-sequence.
      send_bits(16'b011, 3);
      do_reset();
      send_bit(1'b1);
      check("rst_mid_out", int'(out0), 0);
      check("rst_mid_armed", int'(armed0), 0);
      check("rst_mid_cnt", int'(cnt0), 0);

      // Saturation of the 2-bit counter, then clear coincident with a match.
      do_reset();
      repeat (5) send_bits(16'b0111, 4);
      check("sat_cnt", int'(cnt1), 3);
      send_bits(16'b011, 3);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
      check("clr_pulse", int'(out1), 1);
      check("clr_cnt", int'(cnt1), 0);

      // Mask all zeros: every accepted bit matches once armed.
      load(4'h0, 4'h0);
      send_bits(16'b1010110, 7);

      // Randomised traffic.
      for (int n = 0; n < 2000; n++) begin
         logic [3:0] p, mk;
         p  = 4'($urandom);
         mk = ($urandom_range(4) == 0) ? 4'h0 :
              ($urandom_range(1) == 0) ? 4'hF : 4'($urandom);
         step(($urandom_range(99) == 0), ($urandom_range(3) != 0), 1'($urandom),
              ($urandom_range(39) == 0), p, mk, ($urandom_range(49) == 0));
      end

      for (int i = 0; i < 5 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
      #1;
      check("drain", q0.size() + q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
